// File: rtl/jam_param_if.sv
// rtl/jam_param_if.sv - start/result handshake and cost-ROM bus of the job-assignment engine
//
// Signals:
//   START       run request
//   MODE        0 = minimise, 1 = maximise
//   W, J        worker/job address to the cost ROM
//   Cost        cost[W][J], one cycle after the address is sampled
//   MinCost     optimum total of the last completed run
//   MatchCount  number of assignments reaching the optimum (saturating)
//   Valid       result valid (level)
//   BUSY        run in progress
// Modports: slave = engine side, master = controller / ROM side.
interface jam_param_if #(
    parameter int N   = 8,
    parameter int CW  = 7,
    parameter int MCW = 16
);
    localparam int IW = (N > 2) ? $clog2(N) : 1;
    localparam int OW = CW + $clog2(N);

    logic           START;
    logic           MODE;
    logic [IW-1:0]  W;
    logic [IW-1:0]  J;
    logic [CW-1:0]  Cost;
    logic [OW-1:0]  MinCost;
    logic [MCW-1:0] MatchCount;
    logic           Valid;
    logic           BUSY;

    modport slave (
        input  START, MODE, Cost,
        output W, J, MinCost, MatchCount, Valid, BUSY
    );

    modport master (
        output START, MODE, Cost,
        input  W, J, MinCost, MatchCount, Valid, BUSY
    );
endinterface

// File: rtl/jam_param.sv
// rtl/jam_param.sv - exhaustive N-worker/N-job assignment search over an external cost ROM
//
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    jam_param_if.slave: START/MODE in, W/J out, Cost in,
//          MinCost/MatchCount/Valid/BUSY out
module jam_param #(
    parameter int N   = 8,
    parameter int CW  = 7,
    parameter int MCW = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    jam_param_if.slave  bus
);
    localparam int IW = (N > 2) ? $clog2(N) : 1;
    localparam int OW = CW + $clog2(N);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]     state;
    logic [IW-1:0]  p   [N];
    logic [IW-1:0]  sw  [N];
    logic [IW-1:0]  nxt [N];
    logic [IW-1:0]  idx;
    logic [IW-1:0]  piv_a;
    logic [IW-1:0]  piv_b;
    logic           has_pivot;
    logic [OW-1:0]  acc;
    logic [OW-1:0]  best;
    logic [MCW-1:0] count;
    logic           first;
    logic           mode_r;
    logic           better;
    logic [OW-1:0]  min_cost;
    logic [MCW-1:0] match_count;
    logic           valid;
    logic           busy;

    // idx and every p[] entry are always below N, so the ROM address stays in range
    assign bus.W          = idx;
    assign bus.J          = p[idx];
    assign bus.MinCost    = min_cost;
    assign bus.MatchCount = match_count;
    assign bus.Valid      = valid;
    assign bus.BUSY       = busy;

    assign better = mode_r ? (acc > best) : (acc < best);

    // Lexicographic successor computed in one cycle: pivot a, swap partner b,
    // then mirror the suffix after a.
    always_comb begin
        has_pivot = 1'b0;
        piv_a     = '0;
        piv_b     = '0;
        for (int k = 0; k < N - 1; k++) begin
            if (p[k] < p[k+1]) begin
                has_pivot = 1'b1;
                piv_a     = IW'(k);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (k > int'(piv_a) && p[k] > p[piv_a])
                piv_b = IW'(k);
        end
        for (int k = 0; k < N; k++)
            sw[k] = p[k];
        sw[piv_a] = p[piv_b];
        sw[piv_b] = p[piv_a];
        for (int k = 0; k < N; k++)
            nxt[k] = (k > int'(piv_a)) ? sw[IW'(N + int'(piv_a) - k)] : sw[k];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            for (int k = 0; k < N; k++)
                p[k] <= IW'(k);
            idx         <= '0;
            acc         <= '0;
            best        <= '0;
            count       <= '0;
            first       <= 1'b0;
            mode_r      <= 1'b0;
            min_cost    <= '0;
            match_count <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.START) begin
                        mode_r <= bus.MODE;
                        valid  <= 1'b0;
                        busy   <= 1'b1;
                        for (int k = 0; k < N; k++)
                            p[k] <= IW'(k);
                        idx    <= '0;
                        acc    <= '0;
                        first  <= 1'b1;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Cost now on the bus belongs to the address issued one cycle earlier
                    if (idx != '0)
                        acc <= acc + OW'(bus.Cost);
                    if (idx == IW'(N - 1))
                        state <= S_DRAIN;
                    else
                        idx <= idx + 1'b1;
                end
                S_DRAIN: begin
                    acc   <= acc + OW'(bus.Cost);
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    if (first || better) begin
                        best  <= acc;
                        count <= MCW'(1);
                        first <= 1'b0;
                    end else if (acc == best && count != {MCW{1'b1}}) begin
                        count <= count + 1'b1;
                    end
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (has_pivot) begin
                        p     <= nxt;
                        idx   <= '0;
                        acc   <= '0;
                        state <= S_FETCH;
                    end else begin
                        min_cost    <= best;
                        match_count <= count;
                        valid       <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/jam_param.md
Name: jam_param

Overview:
- Parametrised job-assignment engine; successor to the fixed 8x8 JAM.
- Enumerates all N! assignments of N workers to N jobs and reads each cost from an external registered cost ROM through the W/J address ports.
- Reports the optimum total cost (minimum or maximum, selected by MODE) and how many assignments reach it.
- Adds a START/BUSY handshake so the engine can be rerun without reset, plus a max mode and a saturating match counter.

Parameters:
- N, 8, workers = jobs; legal range 2..8.
- CW, 7, cost entry width.
- IW, $clog2(N) (min 1), W/J index width.
- OW, CW+$clog2(N), width of the accumulated total.
- MCW, 16, MatchCount width; count saturates at 2^MCW-1.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  run request; sampled only in IDLE or DONE.
- MODE  in  1  0 = minimise, 1 = maximise; latched when START is accepted.
- W  out  IW  worker index to cost ROM.
- J  out  IW  job index to cost ROM.
- Cost  in  CW  cost[W][J]; valid one cycle after the W/J address is sampled.
- MinCost  out  OW  optimum total (the maximum when MODE=1).
- MatchCount  out  MCW  number of assignments equal to the optimum, saturating.
- Valid  out  1  result valid; level signal.
- BUSY  out  1  high from the START accept edge until Valid rises.

Behaviour:
- Reset (asynchronous, RST_N=0): all outputs 0; state IDLE; permutation register = identity; accumulator, best and count cleared. Reset mid-run aborts the run and produces no result.
- START=1 in IDLE or DONE: latch MODE, clear Valid, set BUSY, load the identity permutation p = 0,1,..,N-1, enter FETCH. START while BUSY is ignored.
- ROM timing: W/J driven in cycle k are captured by the ROM at the end of cycle k. Cost is stable through cycle k+1 and is sampled at the edge ending k+1. One address may be issued every cycle, pipelined.
- States:
  - IDLE.
  - FETCH: issue (W=i, J=p[i]) for i=0..N-1 on consecutive cycles; accumulate each returned Cost.
  - DRAIN: take the last Cost.
  - EVAL: compare the completed sum.
  - NEXT: lexicographic next permutation — find the largest a with p[a]<p[a+1], find the largest b with p[b]>p[a], swap p[a] and p[b], reverse p[a+1..N-1]. This may take several cycles.
  - DONE.
  - From NEXT: return to FETCH; if no pivot a exists (last permutation already evaluated), go to DONE.
- Accumulator is OW bits wide, cleared at the start of each permutation; it cannot overflow.
- EVAL rules:
  - First permutation: best = sum, count = 1.
  - Otherwise, if MODE=0 and sum<best, or MODE=1 and sum>best: best = sum, count = 1.
  - If sum==best: count = count+1, saturating at 2^MCW-1.
  - Otherwise: no change.
- DONE entry: MinCost=best and MatchCount=count are registered; Valid=1 and BUSY=0 on the same edge. Outputs and Valid hold until the next accepted START or reset.
- MinCost and MatchCount do not change while BUSY=1; they hold the previous result, or 0 after reset.
- W/J are unconstrained outside FETCH but must stay below N at all times; they never address a row or column ≥ N.
- Run length: the run completes within N!*(2N+4)+8 cycles of START accept; Valid rising later is a failure.
- N=2: exactly 2 permutations are evaluated, (0,1) then (1,0).

Test Plan:
- N=8, all costs 0, MODE=0 → MinCost=0, MatchCount=40320, Valid within the cycle bound, BUSY low once Valid is high.
- N=8, cost[i][j]=1 if i==j else 100, MODE=0 → MinCost=8, MatchCount=1; rerun with MODE=1 via START, no reset → MinCost=800, MatchCount=14833 (derangements of 8).
- N=4, cost[i][j]=10 if j==(i+1)%4 else 0: MODE=1 → MinCost=40, MatchCount=1; MODE=0 → MinCost=0, MatchCount=9.
- N=4, MCW=4, all costs 3 → MinCost=12, MatchCount=15 (24 saturated); checker confirms W,J<4 on every cycle.
- N=3, all costs 5; pulse START repeatedly while BUSY → ignored; single result MinCost=15, MatchCount=6.
- N=8 run; drive RST_N low mid-FETCH → W, J, Valid, BUSY, MinCost, MatchCount all 0 immediately, with no clock edge needed; after release, START with the diagonal table from scenario 2 → MinCost=8, MatchCount=1.
